// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared widths, status struct and parameter check for fifo_sync_prog
package fifo_sync_pkg;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth - 1) &&
           (ae >= 0) && (ae <= depth - 2);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_mem.sv
// rtl/fifo_sync_mem.sv - register array, synchronous write, asynchronous read index
module fifo_sync_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with count, programmable thresholds and error pulses
// Define FIFO_SYNC_PROG_FWFT_EN for first-word-fall-through output.
module fifo_sync_prog
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int ADDR_W = addr_w(FIFO_DEPTH);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (!params_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("fifo_sync_prog: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  rd_ok, wr_ok;
  fifo_status_t          status;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign rd_ok = cs & rd_en & ~status.empty;
  assign wr_ok = cs & wr_en & (~status.full | rd_ok);

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_ok && !rd_ok)      cnt_nxt = cnt_q + 1'b1;
    else if (rd_ok && !wr_ok) cnt_nxt = cnt_q - 1'b1;
  end

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      status <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1,
                  almost_full: 1'b0, overflow: 1'b0, underflow: 1'b0};
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt_q                <= cnt_nxt;
      status.empty         <= (cnt_nxt == '0);
      status.full          <= (cnt_nxt == DEPTH_C);
      status.almost_empty  <= (cnt_nxt <= AE_C);
      status.almost_full   <= (cnt_nxt >= AF_C);
      status.overflow      <= cs & wr_en & ~wr_ok;
      status.underflow     <= cs & rd_en & status.empty;
    end
  end

`ifdef FIFO_SYNC_PROG_FWFT_EN
  assign data_out = status.empty ? '0 : mem_rd;
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     data_q <= '0;
    else if (rd_ok) data_q <= mem_rd;
  end

  assign data_out = data_q;
`endif

  assign count        = cnt_q;
  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - directed self-checking bench for fifo_sync_prog
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        rst_n, cs, wr_en, rd_en;
  logic [31:0] data_in, data_out;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  count;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (8),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic op(input logic c, input logic w, input logic [31:0] d, input logic r);
    cs = c; wr_en = w; data_in = d; rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op(1, 1, 32'hdead, 0);
    op(1, 1, 32'hdead, 0);
    op(1, 1, 32'hdead, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

`ifndef FIFO_SYNC_PROG_FWFT_EN
    // Basic write then read with almost_empty boundary.
    for (int i = 1; i <= 4; i++) begin
      op(1, 1, i, 0);
      chk("t2_wcount", count, i);
      chk("t2_w_ae", almost_empty, (i <= 2));
    end
    for (int i = 1; i <= 4; i++) begin
      op(1, 0, 0, 1);
      chk("t2_rdata", data_out, i);
      chk("t2_rcount", count, 4 - i);
      chk("t2_r_ae", almost_empty, (4 - i <= 2));
    end
    chk("t2_empty", empty, 1);
    op(0, 0, 0, 0);
    chk("t2_hold", data_out, 4);

    // Fill, overflow, drain.
    for (int i = 0; i < 8; i++) begin
      op(1, 1, i, 0);
      chk("t3_af", almost_full, (i + 1 >= 6));
      chk("t3_full", full, (i == 7));
    end
    op(1, 1, 99, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_ovf_count", count, 8);
    op(1, 0, 0, 0);
    chk("t3_ovf_pulse", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      op(1, 0, 0, 1);
      chk("t3_rdata", data_out, i);
    end
    chk("t3_empty", empty, 1);

    // Simultaneous read+write while full.
    for (int i = 0; i < 8; i++) op(1, 1, 10 + i, 0);
    chk("t4_full", full, 1);
    op(1, 1, 50, 1);
    chk("t4_rw_data", data_out, 10);
    chk("t4_rw_count", count, 8);
    chk("t4_rw_full", full, 1);
    chk("t4_rw_ovf", overflow, 0);
    for (int i = 1; i < 8; i++) begin
      op(1, 0, 0, 1);
      chk("t4_rdata", data_out, 10 + i);
    end
    op(1, 0, 0, 1);
    chk("t4_last", data_out, 50);
    chk("t4_empty", empty, 1);

    // Simultaneous read+write while empty, then cs gating.
    op(1, 1, 7, 1);
    chk("t5_unf", underflow, 1);
    chk("t5_count", count, 1);
    chk("t5_empty", empty, 0);
    chk("t5_dout_hold", data_out, 50);
    op(1, 0, 0, 0);
    chk("t5_unf_pulse", underflow, 0);
    op(1, 0, 0, 1);
    chk("t5_rdata", data_out, 7);
    chk("t5_empty2", empty, 1);
    op(0, 0, 0, 1);
    chk("t5_cs_unf", underflow, 0);
    op(0, 1, 33, 0);
    chk("t5_cs_count", count, 0);
    chk("t5_cs_ovf", overflow, 0);
`else
    // First-word-fall-through behaviour.
    op(1, 1, 32'hA5, 0);
    chk("t6_empty", empty, 0);
    chk("t6_fwft", data_out, 32'hA5);
    op(1, 0, 0, 0);
    chk("t6_hold", data_out, 32'hA5);
    op(1, 1, 32'hB1, 1);
    chk("t6_next", data_out, 32'hB1);
    chk("t6_count", count, 1);
    op(1, 0, 0, 1);
    chk("t6_pop_empty", empty, 1);
    chk("t6_pop_dout", data_out, 0);
    op(1, 0, 0, 1);
    chk("t6_unf", underflow, 1);
    for (int i = 0; i < 9; i++) op(1, 1, 32'hC0 + i, 0);
    chk("t6_ovf", overflow, 1);
    chk("t6_full_head", data_out, 32'hC0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
